// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the RAM port.
// Masters drive the m_* requests; the RAM drives s_gnt/s_rvalid/s_rdata.
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]              m_req_i;
  logic [1:0]              m_gnt_o;
  logic [1:0]              m_rvalid_o;
  logic [2*ADDR_WIDTH-1:0] m_addr_i;
  logic [1:0]              m_we_i;
  logic [2*DATA_WIDTH-1:0] m_wdata_i;
  logic [DATA_WIDTH-1:0]   m_rdata_o;
  logic                    s_req_o;
  logic                    s_gnt_i;
  logic                    s_rvalid_i;
  logic [ADDR_WIDTH-1:0]   s_addr_o;
  logic                    s_we_o;
  logic [DATA_WIDTH-1:0]   s_wdata_o;
  logic [DATA_WIDTH-1:0]   s_rdata_i;
  logic                    timeout_o;

  modport master (
    output m_req_i, m_addr_i, m_we_i, m_wdata_i,
    output s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o,
    input  s_req_o, s_addr_o, s_we_o, s_wdata_o,
    input  timeout_o
  );

  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_wdata_i,
    input  s_gnt_i, s_rvalid_i, s_rdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o,
    output s_req_o, s_addr_o, s_we_o, s_wdata_o,
    output timeout_o
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin two-master arbiter for a single-port RAM with one
// outstanding transaction, captured read data and response timeout.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst_n,
  ram_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RESP_TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  prio_q, prio_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic                  tout_q, tout_d;
  logic                  eligible, sel, req, hs;

  always_comb begin
    eligible = (state_q == IDLE) | bus.s_rvalid_i;
    sel      = bus.m_req_i[prio_q] ? prio_q : ~prio_q;
    req      = eligible & (|bus.m_req_i);
    hs       = req & bus.s_gnt_i;
  end

  assign bus.s_req_o   = req;
  assign bus.s_addr_o  = sel ? bus.m_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                             : bus.m_addr_i[ADDR_WIDTH-1:0];
  assign bus.s_wdata_o = sel ? bus.m_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                             : bus.m_wdata_i[DATA_WIDTH-1:0];
  assign bus.s_we_o    = hs & bus.m_we_i[sel];
  assign bus.m_gnt_o   = {hs & sel, hs & ~sel};

  assign bus.m_rvalid_o = rvalid_q;
  assign bus.m_rdata_o  = out_q;
  assign bus.timeout_o  = tout_q;

  // Saturating wait counter; never wraps back to zero.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    out_d    = out_q;
    rvalid_d = 2'b00;
    tout_d   = tout_q;

    unique case (state_q)
      IDLE: begin
      end
      WAIT: begin
        if (bus.s_rvalid_i) begin
          rvalid_d[owner_q] = 1'b1;
          out_d             = rdata_q;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            tout_d            = 1'b1;
            rvalid_d[owner_q] = 1'b1;
            out_d             = '0;
            state_d           = IDLE;
          end
        end
      end
    endcase

    // A new handshake overrides the return to IDLE (back-to-back).
    if (hs) begin
      rdata_d = bus.s_rdata_i;
      owner_d = sel;
      prio_d  = ~sel;
      cnt_d   = '0;
      state_d = WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      out_q    <= '0;
      rvalid_q <= 2'b00;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      out_q    <= out_d;
      rvalid_q <= rvalid_d;
      tout_q   <= tout_d;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM stub, cycle vector table, response
// scoreboard and hand sequences for reset, spurious rvalid and timeout.
module tb_ram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic        gnt_en = 1'b1;
  logic        rv_block = 1'b0;
  logic        spur = 1'b0;
  logic        ram_rv = 1'b0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = 4'd0;
  logic [31:0] pl_data = 32'd0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  assign bus.s_gnt_i    = gnt_en;
  assign bus.s_rvalid_i = ram_rv | spur;
  assign bus.s_rdata_i  = mem[bus.s_addr_o[3:0]];

  // One-cycle RAM: response valid the cycle after each handshake.
  always @(posedge clk) begin
    ram_rv <= bus.s_req_o & bus.s_gnt_i & ~rv_block;
    if (bus.s_we_o) mem[bus.s_addr_o[3:0]] <= bus.s_wdata_o;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit sb_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        k;
    logic [31:0] data;
    logic        dc;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        ep, eq;
  logic        gk;
  logic [3:0]  ga;

  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (bus.m_rvalid_o != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("rvalid_unexpected", 64'(bus.m_rvalid_o), 64'd0);
        end else begin
          eq = sbq.pop_front();
          chk("rvalid_owner", 64'(bus.m_rvalid_o),
              eq.k ? 64'd2 : 64'd1);
          chk("rvalid_latency", 64'(cyc), 64'(eq.cyc + 2));
          if (!eq.dc) chk("rdata", 64'(bus.m_rdata_o), 64'(eq.data));
        end
      end
      if (bus.m_gnt_o != 2'b00) begin
        gk = bus.m_gnt_o[1];
        ga = gk ? bus.m_addr_i[AW+3:AW] : bus.m_addr_i[3:0];
        ep.k = gk;
        ep.cyc = cyc;
        ep.dc = bus.m_we_i[gk];
        ep.data = ref_mem[ga];
        if (bus.m_we_i[gk])
          ref_mem[ga] = gk ? bus.m_wdata_i[DW+31:DW] : bus.m_wdata_i[31:0];
        sbq.push_back(ep);
      end
    end
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        g;
    logic [1:0]  gnt;
    logic        sreq;
    logic        swe;
  } vec_t;

  vec_t vt[27];

  task automatic drive(logic [1:0] req, logic [1:0] we, logic [3:0] a0,
                       logic [3:0] a1, logic [31:0] wd0, logic [31:0] wd1,
                       logic g);
    bus.m_req_i   = req;
    bus.m_we_i    = we;
    bus.m_addr_i  = {28'd0, a1, 28'd0, a0};
    bus.m_wdata_i = {wd1, wd0};
    gnt_en        = g;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_val(int i);
    case (i)
      1: return 32'h1111_1111;
      2: return 32'h2222_2222;
      5: return 32'hDEAD_BEEF;
      default: return 32'hC000_0000 + 32'(i);
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{2'b01, 2'b00, 4'd5, 4'd0, 32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0};
    vt[1]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[2]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[3]  = '{2'b11, 2'b00, 4'd1, 4'd2, 32'h0, 32'h0, 1'b1, 2'b10, 1'b1, 1'b0};
    vt[4]  = '{2'b11, 2'b00, 4'd1, 4'd2, 32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0};
    vt[5]  = '{2'b11, 2'b00, 4'd1, 4'd2, 32'h0, 32'h0, 1'b1, 2'b10, 1'b1, 1'b0};
    vt[6]  = '{2'b11, 2'b00, 4'd1, 4'd2, 32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0};
    vt[7]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[8]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[9]  = '{2'b10, 2'b10, 4'd0, 4'd4, 32'h0, 32'h1234_5678, 1'b1, 2'b10, 1'b1, 1'b1};
    vt[10] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[11] = '{2'b01, 2'b00, 4'd4, 4'd0, 32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0};
    vt[12] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[13] = '{2'b01, 2'b00, 4'd5, 4'd0, 32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0};
    vt[14] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[15] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[16] = '{2'b01, 2'b01, 4'd6, 4'd0, 32'hCAFE_F00D, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0};
    vt[17] = '{2'b01, 2'b01, 4'd6, 4'd0, 32'hCAFE_F00D, 32'h0, 1'b1, 2'b01, 1'b1, 1'b1};
    vt[18] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[19] = '{2'b01, 2'b00, 4'd6, 4'd0, 32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0};
    vt[20] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[21] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[22] = '{2'b11, 2'b01, 4'd7, 4'd7, 32'h7777_0000, 32'h0, 1'b1, 2'b10, 1'b1, 1'b0};
    vt[23] = '{2'b11, 2'b01, 4'd7, 4'd7, 32'h7777_0000, 32'h0, 1'b1, 2'b01, 1'b1, 1'b1};
    vt[24] = '{2'b10, 2'b00, 4'd7, 4'd7, 32'h0, 32'h0, 1'b1, 2'b10, 1'b1, 1'b0};
    vt[25] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[26] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0};

    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pl_en = 1'b1;
      pl_addr = 4'(i);
      pl_data = init_val(i);
      ref_mem[i] = init_val(i);
      next_cycle();
    end
    pl_en = 1'b0;

    @(negedge clk);
    chk("reset_rvalid", 64'(bus.m_rvalid_o), 64'd0);
    chk("reset_rdata", 64'(bus.m_rdata_o), 64'd0);
    chk("reset_timeout", 64'(bus.timeout_o), 64'd0);
    chk("reset_sreq", 64'(bus.s_req_o), 64'd0);
    chk("reset_gnt", 64'(bus.m_gnt_o), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    sb_en = 1'b1;

    for (int i = 0; i < 27; i++) begin
      drive(vt[i].req, vt[i].we, vt[i].a0, vt[i].a1,
            vt[i].wd0, vt[i].wd1, vt[i].g);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 64'(bus.m_gnt_o), 64'(vt[i].gnt));
      chk($sformatf("v%0d_sreq", i), 64'(bus.s_req_o), 64'(vt[i].sreq));
      chk($sformatf("v%0d_swe", i), 64'(bus.s_we_o), 64'(vt[i].swe));
      next_cycle();
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1);
    repeat (3) next_cycle();
    chk("table_sb_drained", 64'(sbq.size()), 64'd0);

    // Spurious rvalid while idle must not pulse or disturb priority.
    spur = 1'b1;
    @(negedge clk);
    chk("spur_sreq", 64'(bus.s_req_o), 64'd0);
    next_cycle();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_rvalid", 64'(bus.m_rvalid_o), 64'd0);
    next_cycle();
    drive(2'b11, 2'b00, 4'd1, 4'd2, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("spur_prio_gnt", 64'(bus.m_gnt_o), 64'd1);
    next_cycle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1);
    repeat (3) next_cycle();
    chk("spur_sb_drained", 64'(sbq.size()), 64'd0);
    sb_en = 1'b0;

    // Reset in the cycle after a grant discards the response.
    drive(2'b01, 2'b00, 4'd5, 4'd0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("rst_mid_gnt", 64'(bus.m_gnt_o), 64'd1);
    next_cycle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1);
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_rvalid%0d", i), 64'(bus.m_rvalid_o), 64'd0);
      next_cycle();
    end
    drive(2'b11, 2'b00, 4'd5, 4'd2, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("rst_first_gnt", 64'(bus.m_gnt_o), 64'd1);
    next_cycle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("rst_first_rvalid", 64'(bus.m_rvalid_o), 64'd1);
    chk("rst_first_rdata", 64'(bus.m_rdata_o), 64'hDEAD_BEEF);
    next_cycle();

    // RAM grants but never answers: timeout after RT waiting cycles.
    rv_block = 1'b1;
    drive(2'b01, 2'b00, 4'd3, 4'd2, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("to_gnt", 64'(bus.m_gnt_o), 64'd1);
    next_cycle();
    drive(2'b10, 2'b00, 4'd3, 4'd2, 32'h0, 32'h0, 1'b1);
    for (int i = 1; i <= RT; i++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d_gnt", i), 64'(bus.m_gnt_o), 64'd0);
      chk($sformatf("to_wait%0d_flag", i), 64'(bus.timeout_o), 64'd0);
      chk($sformatf("to_wait%0d_rv", i), 64'(bus.m_rvalid_o), 64'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("to_flag", 64'(bus.timeout_o), 64'd1);
    chk("to_rvalid", 64'(bus.m_rvalid_o), 64'd1);
    chk("to_rdata", 64'(bus.m_rdata_o), 64'd0);
    chk("to_next_gnt", 64'(bus.m_gnt_o), 64'd2);
    next_cycle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("to_pulse_once", 64'(bus.m_rvalid_o), 64'd0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("to_sticky%0d", i), 64'(bus.timeout_o), 64'd1);
      next_cycle();
    end
    rst_n = 1'b0;
    rv_block = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("to_cleared", 64'(bus.timeout_o), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-master, single-slave request/grant arbiter placed directly upstream of the single-port data RAM.
- Lets both redundant cores (or one core's instruction and data ports) share the RAM's single req/gnt/rvalid port.
- Round-robin fairness, one outstanding transaction.
- Read data is captured at the grant cycle and returned with rvalid, so it stays correct against the RAM's combinational read.

Parameters:
- ADDR_WIDTH, 32, address width; passed through unmodified (word index as the RAM uses it).
- DATA_WIDTH, 32, read/write data width.
- RESP_TIMEOUT, 15, cycles to wait for s_rvalid_i after a grant before flagging an error; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- m_req_i  in  2  per-master request
- m_gnt_o  out  2  per-master grant (combinational)
- m_rvalid_o  out  2  per-master response valid (registered)
- m_addr_i  in  2*ADDR_WIDTH  per-master address; master k uses slice k
- m_we_i  in  2  per-master write enable
- m_wdata_i  in  2*DATA_WIDTH  per-master write data
- m_rdata_o  out  DATA_WIDTH  shared read data; valid where m_rvalid_o[k]=1
- s_req_o  out  1  request to RAM
- s_gnt_i  in  1  RAM grant
- s_rvalid_i  in  1  RAM response valid
- s_addr_o  out  ADDR_WIDTH  address to RAM
- s_we_o  out  1  write enable to RAM; gated by grant
- s_wdata_o  out  DATA_WIDTH  write data to RAM
- s_rdata_i  in  DATA_WIDTH  RAM read data (combinational from s_addr_o)
- timeout_o  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (rst_n=0, async): m_rvalid_o=0, m_rdata_o=0, timeout_o=0, pending=0, owner=0, prio=0, wait counter=0. Combinational outputs follow from these values with s_req_o=0.
- State FSM:
  - IDLE: no transaction outstanding.
  - WAIT: pending=1; owner holds the master index.
- Arbitration (combinational):
  - eligible = IDLE, or WAIT with s_rvalid_i=1 this cycle (back-to-back allowed).
  - If eligible and any m_req_i: sel = prio if m_req_i[prio], else the other requesting master.
  - s_req_o=1; s_addr_o, s_wdata_o and s_we_o are muxed from sel.
  - s_we_o = m_we_i[sel] & s_req_o & s_gnt_i, so the RAM never sees a write without a grant.
  - When not eligible, s_req_o=0 and s_we_o=0.
- Grant: m_gnt_o[sel] = s_req_o & s_gnt_i. At most one bit set. Zero when not eligible.
- On a handshake (s_req_o & s_gnt_i):
  - capture s_rdata_i into rdata_q, owner<=sel, prio<=~sel, go WAIT, reset wait counter.
  - For writes, rdata_q still captures (don't-care value), and rvalid is still returned.
- In WAIT with s_rvalid_i=1:
  - m_rvalid_o[owner]<=1 for exactly one cycle; m_rdata_o<=rdata_q.
  - If no new handshake in the same cycle, go IDLE.
- m_rvalid_o is registered and lags s_rvalid_i by one cycle.
  - Latency from master grant to master rvalid = 2 cycles with a 1-cycle RAM.
  - m_rdata_o holds its last value when rvalid is 0.
- s_rvalid_i in IDLE: ignored, no m_rvalid_o pulse.
- Timeout:
  - In WAIT without s_rvalid_i, the counter increments.
  - When the count reaches RESP_TIMEOUT: timeout_o<=1, m_rvalid_o[owner] pulses with m_rdata_o=0, state goes IDLE.
  - The counter saturates; it never wraps.
- Priority: prio toggles only on a handshake. A lone requester is granted regardless of prio.
- Reset mid-transaction: pending response discarded, no rvalid after release; first grant after reset goes to master 0 if both request.

Test Plan:
- Reset, RAM mem[5]=0xDEADBEEF, m0 reads addr 5 -> m_gnt_o=01 in cycle 0; m_rvalid_o=01 with m_rdata_o=0xDEADBEEF in cycle 2; m_rvalid_o=00 in cycle 3.
- Both masters request continuously, m0 reading addr 1, m1 reading addr 2 -> grants alternate 01,10,01,10 on consecutive cycles; 4 rvalid pulses in matching owner order, each with correct data.
- m1 writes 0x12345678 to addr 4 while m0 is idle -> s_we_o=1 for one cycle; a subsequent m0 read of addr 4 returns 0x12345678.
- Slave stub holds s_gnt_i=1 but never asserts s_rvalid_i, m0 reads -> no further grants for 15 cycles; then timeout_o=1, one m_rvalid_o[0] pulse with data 0; timeout_o stays 1 until reset.
- Assert rst_n=0 in the cycle after a grant -> m_rvalid_o stays 00 after release; first simultaneous request afterwards grants m0.
- Spurious s_rvalid_i=1 while idle -> m_rvalid_o stays 00; state and priority unchanged.
